// File: rtl/jpg_pkg.sv
// Shared definitions for the jpg block feeder: block geometry, channel and
// planarizer state encodings, and per-channel byte lanes of a packed RGB pixel.
package jpg_pkg;

    localparam int BLOCK_PIXELS      = 64;
    localparam int WORDS_PER_CHANNEL = 16;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_e;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DRAIN_R = 2'd1,
        ST_DRAIN_G = 2'd2,
        ST_DRAIN_B = 2'd3
    } pl_state_e;

    function automatic logic [7:0] ch_byte(input logic [23:0] pix, input ch_e ch);
        case (ch)
            CH_R:    return pix[R_LSB +: 8];
            CH_G:    return pix[G_LSB +: 8];
            default: return pix[B_LSB +: 8];
        endcase
    endfunction

endpackage

// File: rtl/jpg_axis_out_reg.sv
// Single-entry AXI-Stream output register; o_ld tells the producer when a
// new word will be captured on the next edge.
module jpg_axis_out_reg #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_rdy,
    output logic         o_ld,
    output logic         o_vld,
    output logic [W-1:0] o_data,
    output logic         o_last
);

    logic         r_vld;
    logic [W-1:0] r_data;
    logic         r_last;

    assign o_ld   = !r_vld || i_rdy;
    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_last = r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (o_ld) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end

endmodule

// File: rtl/jpg_block_planarizer.sv
// Buffers one 8x8 block of packed RGB pixels and replays it as three planar
// 16-word packets (R, G, B), 4 pixels of one channel per word.
module jpg_block_planarizer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int BLOCK_PIXELS           = 64
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    input  logic                                  s00_axis_tvalid,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready,
    output logic                                  len_err,
    output logic                                  block_done
);
    import jpg_pkg::*;

    localparam logic [5:0] LAST_PIX  = 6'(jpg_pkg::BLOCK_PIXELS - 1);
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_CHANNEL - 1);

    pl_state_e r_state, w_next;
    logic [5:0]              r_cnt;
    logic [3:0]              r_widx;
    logic                    r_pushed_all;
    logic [BLOCK_PIXELS-1:0] r_mask;
    logic [23:0]             r_pix [0:BLOCK_PIXELS-1];
    logic                    r_tready, r_len_err, r_done;

    logic       w_in_hs, w_fill_exit, w_ld, w_push, w_out_hs, w_blk_end;
    logic       w_src_vld;
    ch_e        w_ch;
    logic [3:0] w_widx;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_word;
    logic       w_unused;

    assign w_unused    = &{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:24]};
    assign w_in_hs     = s00_axis_tvalid && r_tready;
    assign w_fill_exit = w_in_hs && (r_cnt == LAST_PIX || s00_axis_tlast);
    assign w_push      = w_src_vld && w_ld;
    assign w_out_hs    = m00_axis_tvalid && m00_axis_tready;
    // Only B word 15 can still be in the output register once every word is pushed.
    assign w_blk_end   = (r_state == ST_DRAIN_B) && r_pushed_all && w_out_hs;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) r_state <= ST_FILL;
        else                   r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FILL:    if (w_fill_exit) w_next = ST_DRAIN_R;
            ST_DRAIN_R: if (w_push && r_widx == LAST_WORD) w_next = ST_DRAIN_G;
            ST_DRAIN_G: if (w_push && r_widx == LAST_WORD) w_next = ST_DRAIN_B;
            default:    if (w_blk_end) w_next = ST_FILL;
        endcase
    end

    // The closing input handshake pushes R word 0 directly, so the first
    // output word is valid one cycle after the last pixel.
    always_comb begin
        w_src_vld = 1'b0;
        w_ch      = CH_R;
        w_widx    = r_widx;
        case (r_state)
            ST_FILL: begin
                w_src_vld = w_fill_exit;
                w_widx    = 4'd0;
            end
            ST_DRAIN_R: w_src_vld = 1'b1;
            ST_DRAIN_G: begin
                w_src_vld = 1'b1;
                w_ch      = CH_G;
            end
            default: begin
                w_src_vld = !r_pushed_all;
                w_ch      = CH_B;
            end
        endcase
    end

    // Pixel currently being written is forwarded; unwritten pixels read as 0.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [5:0]  w_idx;
        logic [23:0] w_pix;
        assign w_idx = {w_widx, 2'(g)};
        assign w_pix = (r_state == ST_FILL && w_in_hs && w_idx == r_cnt) ? s00_axis_tdata[23:0] :
                       r_mask[w_idx] ? r_pix[w_idx] : 24'd0;
        assign w_word[8*g +: 8] = ch_byte(w_pix, w_ch);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (w_in_hs) r_pix[r_cnt] <= s00_axis_tdata[23:0];
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_cnt        <= '0;
            r_widx       <= '0;
            r_pushed_all <= 1'b0;
            r_mask       <= '0;
            r_tready     <= 1'b0;
            r_len_err    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tready <= (w_next == ST_FILL);
            r_done   <= w_blk_end;
            if (w_in_hs) begin
                r_mask[r_cnt] <= 1'b1;
                r_cnt         <= w_fill_exit ? 6'd0 : r_cnt + 6'd1;
                if ((r_cnt == LAST_PIX) != s00_axis_tlast) r_len_err <= 1'b1;
            end
            if (w_push) begin
                r_widx <= r_widx + 4'd1;
                if (r_state == ST_DRAIN_B && r_widx == LAST_WORD) r_pushed_all <= 1'b1;
            end
            if (w_blk_end) begin
                r_pushed_all <= 1'b0;
                r_mask       <= '0;
            end
        end
    end

    jpg_axis_out_reg #(.W(C_M00_AXIS_TDATA_WIDTH)) u_out (
        .i_clk   (s00_axis_aclk),
        .i_rst_n (s00_axis_aresetn),
        .i_vld   (w_src_vld),
        .i_data  (w_word),
        .i_last  (w_widx == LAST_WORD),
        .i_rdy   (m00_axis_tready),
        .o_ld    (w_ld),
        .o_vld   (m00_axis_tvalid),
        .o_data  (m00_axis_tdata),
        .o_last  (m00_axis_tlast)
    );

    assign s00_axis_tready = r_tready;
    assign m00_axis_tstrb  = '1;
    assign len_err         = r_len_err;
    assign block_done      = r_done;

endmodule
